// File: rtl/sgd_cmd_pkg.sv
// Shared types and constants for the SGD memory-read command arbiter.
package sgd_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int MAX_BURST_DEF = 4096;
  localparam int TAG_W_DEF     = 8;
  localparam int TAG_LAST_BIT  = TAG_W_DEF - 1;

  // Width of the channel field in the tag; never zero so it can always be sliced.
  function automatic int ch_field_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sgd_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NUM_CH.
module sgd_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_req
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the closest requester wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (req[cand]) begin
        grant_idx = cand;
        any_req   = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/sgd_mem_cmd_arbiter.sv
// N-channel read-command arbiter with MAX_BURST boundary splitting and a parallel tag stream.
// Boundary splitting is built only when SGD_CMD_SPLIT_EN is defined; otherwise one chunk per command.
module sgd_mem_cmd_arbiter
  import sgd_cmd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        s_cmd_valid,
  output logic [NUM_CH-1:0]        s_cmd_ready,
  input  logic [NUM_CH*ADDR_W-1:0] s_cmd_address,
  input  logic [NUM_CH*LEN_W-1:0]  s_cmd_length,
  output logic                     m_cmd_valid,
  input  logic                     m_cmd_ready,
  output logic [ADDR_W-1:0]        m_cmd_address,
  output logic [LEN_W-1:0]         m_cmd_length,
  output logic                     m_tag_valid,
  input  logic                     m_tag_ready,
  output logic [TAG_W-1:0]         m_tag_data,
  output logic                     busy,
  output logic [31:0]              chunk_count
);

  localparam int CH_W = ch_field_w(NUM_CH);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              cmd_done_q, cmd_done_d;
  logic              tag_done_q, tag_done_d;
  logic [31:0]       chunk_count_q, chunk_count_d;

  logic [ADDR_W-1:0] req_addr [NUM_CH];
  logic [LEN_W-1:0]  req_len  [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign req_addr[gi] = s_cmd_address[gi*ADDR_W +: ADDR_W];
      assign req_len[gi]  = s_cmd_length[gi*LEN_W +: LEN_W];
    end
  endgenerate

  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;

  sgd_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_rr (
    .req       (s_cmd_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (grant_any)
  );

  logic [LEN_W-1:0] chunk_len;
  logic             chunk_last;

`ifdef SGD_CMD_SPLIT_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(MAX_BURST - 1);
  logic [LEN_W-1:0] room;
  // Bytes left before the next MAX_BURST boundary; a full burst when aligned.
  assign room      = LEN_W'(MAX_BURST) - LEN_W'(addr_q & OFF_MASK);
  assign chunk_len = (rem_q < room) ? rem_q : room;
`else
  assign chunk_len = rem_q;
`endif
  assign chunk_last = (chunk_len == rem_q);

  logic [TAG_W-1:0] tag_word;
  always_comb begin
    tag_word            = '0;
    tag_word[CH_W-1:0]  = ch_q;
    tag_word[TAG_W-1]   = chunk_last;
  end

  assign busy          = (state_q != ST_IDLE);
  assign m_cmd_valid   = (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !cmd_done_q);
  assign m_tag_valid   = (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !tag_done_q);
  // Payloads are forced to zero in IDLE so stale latched values never show.
  assign m_cmd_address = busy ? addr_q : '0;
  assign m_cmd_length  = busy ? chunk_len : '0;
  assign m_tag_data    = busy ? tag_word : '0;
  assign s_cmd_ready   = (state_q == ST_IDLE) ? grant_oh : '0;
  assign chunk_count   = chunk_count_q;

  logic cmd_hs, tag_hs;
  assign cmd_hs = m_cmd_valid && m_cmd_ready;
  assign tag_hs = m_tag_valid && m_tag_ready;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ch_d          = ch_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    cmd_done_d    = cmd_done_q;
    tag_done_d    = tag_done_q;
    chunk_count_d = chunk_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          addr_d     = req_addr[grant_idx];
          rem_d      = req_len[grant_idx];
          ch_d       = grant_idx;
          rr_ptr_d   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
          cmd_done_d = 1'b0;
          tag_done_d = 1'b0;
          if (req_len[grant_idx] != '0) state_d = ST_ISSUE;
        end
      end
      default: begin
        if ((cmd_done_q || cmd_hs) && (tag_done_q || tag_hs)) begin
          addr_d        = addr_q + ADDR_W'(chunk_len);
          rem_d         = rem_q - chunk_len;
          chunk_count_d = chunk_count_q + 32'd1;
          cmd_done_d    = 1'b0;
          tag_done_d    = 1'b0;
          state_d       = chunk_last ? ST_IDLE : ST_ISSUE;
        end else if (cmd_hs || tag_hs) begin
          cmd_done_d = cmd_done_q || cmd_hs;
          tag_done_d = tag_done_q || tag_hs;
          state_d    = ST_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      ch_q          <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      cmd_done_q    <= 1'b0;
      tag_done_q    <= 1'b0;
      chunk_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ch_q          <= ch_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      cmd_done_q    <= cmd_done_d;
      tag_done_q    <= tag_done_d;
      chunk_count_q <= chunk_count_d;
    end
  end

endmodule
